// File: rtl/instr_fetcher.sv
// Instruction fetcher with a single outstanding memory request, redirect/drain handling and fault capture.
// Optional build macro INSTR_FETCHER_MISALIGN_CHECK_EN: misaligned PCs raise a fetch exception instead of fetching.
package instr_fetcher_pkg;

  typedef logic [3:0] if_reason_t;

  localparam if_reason_t IF_PREFETCH = 4'b0000;
  localparam if_reason_t IF_FLUSH    = 4'b1111;

  typedef struct packed {
    logic        valid;
    logic        mcause_interrupt;
    logic [3:0]  mcause_code;
    logic [63:0] mtval;
  } exception_t;

  typedef struct packed {
    logic [63:0] pc;
    if_reason_t  if_reason;
    logic [31:0] instr_word;
    exception_t  exception;
  } fetched_instr_t;

endpackage

module instr_fetcher
  import instr_fetcher_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           redirect_valid_i,
  input  logic [63:0]    redirect_pc_i,
  input  logic [3:0]     redirect_reason_i,
  output logic           mem_req_valid_o,
  input  logic           mem_req_ready_i,
  output logic [63:0]    mem_req_addr_o,
  input  logic           mem_resp_valid_i,
  input  logic [31:0]    mem_resp_data_i,
  input  logic           mem_resp_exception_i,
  input  logic [3:0]     mem_resp_exception_code_i,
  output logic           fetch_valid_o,
  input  logic           fetch_ready_i,
  output fetched_instr_t fetch_instr_o
);

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN,
    S_STALL
  } state_t;

  state_t         r_state;
  logic [63:0]    r_pc;
  if_reason_t     r_reason;
  fetched_instr_t r_instr;
  logic           r_req_valid;
  logic           r_fetch_valid;

  logic           w_outstanding;
  logic           w_redir_misaligned;
  logic           w_pc_misaligned;
  fetched_instr_t w_resp_instr;

  function automatic fetched_instr_t misalign_fault(input logic [63:0] pc, input if_reason_t reason);
    fetched_instr_t f;
    f                       = '0;
    f.pc                    = pc;
    f.if_reason             = reason;
    f.exception.valid       = 1'b1;
    f.exception.mcause_code = 4'd0;
    f.exception.mtval       = pc;
    return f;
  endfunction

`ifdef INSTR_FETCHER_MISALIGN_CHECK_EN
  assign w_redir_misaligned = (redirect_pc_i[1:0] != 2'b00);
  assign w_pc_misaligned    = (r_pc[1:0] != 2'b00);
`else
  assign w_redir_misaligned = 1'b0;
  assign w_pc_misaligned    = 1'b0;
`endif

  // A request is still in flight after this edge if it is accepted now or its response has not arrived.
  assign w_outstanding = ((r_state == S_REQ) && mem_req_ready_i) ||
                         (((r_state == S_WAIT) || (r_state == S_DRAIN)) && !mem_resp_valid_i);

  always_comb begin
    w_resp_instr           = '0;
    w_resp_instr.pc        = r_pc;
    w_resp_instr.if_reason = r_reason;
    if (mem_resp_exception_i) begin
      w_resp_instr.exception.valid       = 1'b1;
      w_resp_instr.exception.mcause_code = mem_resp_exception_code_i;
      w_resp_instr.exception.mtval       = r_pc;
    end else begin
      w_resp_instr.instr_word = mem_resp_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state       <= S_REQ;
      r_pc          <= RESET_PC;
      r_reason      <= IF_FLUSH;
      r_instr       <= '0;
      r_req_valid   <= 1'b1;
      r_fetch_valid <= 1'b0;
    end else if (redirect_valid_i) begin
      r_pc          <= redirect_pc_i;
      r_reason      <= redirect_reason_i;
      r_fetch_valid <= 1'b0;
      if (w_outstanding) begin
        r_state     <= S_DRAIN;
        r_req_valid <= 1'b0;
      end else if (w_redir_misaligned) begin
        r_state       <= S_HOLD;
        r_req_valid   <= 1'b0;
        r_instr       <= misalign_fault(redirect_pc_i, redirect_reason_i);
        r_fetch_valid <= 1'b1;
      end else begin
        r_state     <= S_REQ;
        r_req_valid <= 1'b1;
      end
    end else begin
      case (r_state)
        S_REQ: begin
          if (mem_req_ready_i) begin
            r_state     <= S_WAIT;
            r_req_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid_i) begin
            r_state       <= S_HOLD;
            r_instr       <= w_resp_instr;
            r_fetch_valid <= 1'b1;
          end
        end
        S_HOLD: begin
          if (fetch_ready_i) begin
            r_fetch_valid <= 1'b0;
            if (r_instr.exception.valid) begin
              r_state <= S_STALL;
            end else begin
              r_pc        <= r_pc + 64'd4;
              r_reason    <= IF_PREFETCH;
              r_state     <= S_REQ;
              r_req_valid <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          // The stale response is swallowed; the PC may have been retargeted while draining.
          if (mem_resp_valid_i) begin
            if (w_pc_misaligned) begin
              r_state       <= S_HOLD;
              r_instr       <= misalign_fault(r_pc, r_reason);
              r_fetch_valid <= 1'b1;
            end else begin
              r_state     <= S_REQ;
              r_req_valid <= 1'b1;
            end
          end
        end
        S_STALL: begin
          r_req_valid <= 1'b0;
        end
        default: begin
          r_state     <= S_STALL;
          r_req_valid <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req_valid_o = r_req_valid;
  assign mem_req_addr_o  = {r_pc[63:2], 2'b00};
  assign fetch_valid_o   = r_fetch_valid & ~redirect_valid_i;
  assign fetch_instr_o   = r_instr;

endmodule
